// File: rtl/alu_pkg.sv
// Opcode encoding and helpers shared by the sequential integer / M-extension ALU.
package alu_pkg;

  localparam int XLEN_DEF = 64;

  typedef enum logic [4:0] {
    OP_XOR   = 5'd0,
    OP_ADD   = 5'd1,
    OP_SUB   = 5'd2,
    OP_AND   = 5'd3,
    OP_OR    = 5'd4,
    OP_SLL   = 5'd5,
    OP_SRL   = 5'd6,
    OP_SRA   = 5'd7,
    OP_EQ    = 5'd8,
    OP_NE    = 5'd9,
    OP_LT    = 5'd10,
    OP_LTU   = 5'd11,
    OP_MUL   = 5'd12,
    OP_MULHU = 5'd13,
    OP_DIVU  = 5'd14,
    OP_REMU  = 5'd15,
    OP_DIV   = 5'd16,
    OP_REM   = 5'd17
  } alu_op_e;

  function automatic logic is_muldiv(input logic [4:0] op);
    return (op >= 5'd12) && (op <= 5'd17);
  endfunction

endpackage

// File: rtl/seq_alu_muldiv_iter.sv
// Iterative radix-2 multiplier / restoring divider sharing one 2*XLEN shift register.
module muldiv_iter
  import alu_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            start,
  input  logic            is_div,
  input  logic            sgn,
  input  logic            sel_hi,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] res
);

  localparam int CW = $clog2(XLEN) + 1;

  logic [2*XLEN-1:0] prod_q, prod_step;
  logic [XLEN-1:0]   opb_q, a_mag, b_mag, half;
  logic [CW-1:0]     cnt_q;
  logic              active_q, is_div_q, sel_hi_q, neg_q;
  logic [XLEN:0]     sum, rem_try, diff;

  assign a_mag = (sgn && a[XLEN-1]) ? -a : a;
  assign b_mag = (sgn && b[XLEN-1]) ? -b : b;

  // Multiply: {hi,lo} accumulates into hi and shifts right.
  // Divide: {rem,dividend} shifts left, quotient bits enter at the bottom.
  always_comb begin
    sum     = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, opb_q} : '0);
    rem_try = prod_q[2*XLEN-1:XLEN-1];
    diff    = rem_try - {1'b0, opb_q};
    if (is_div_q) begin
      prod_step = diff[XLEN] ? {rem_try[XLEN-1:0], prod_q[XLEN-2:0], 1'b0}
                             : {diff[XLEN-1:0],    prod_q[XLEN-2:0], 1'b1};
    end else begin
      prod_step = {sum, prod_q[XLEN-1:1]};
    end
  end

  // Final result is taken from the last step so DONE is entered on the XLEN-th edge.
  assign half = sel_hi_q ? prod_step[2*XLEN-1:XLEN] : prod_step[XLEN-1:0];
  assign res  = neg_q ? -half : half;
  assign busy = active_q;
  assign done = active_q && (cnt_q == CW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q   <= '0;
      opb_q    <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
      is_div_q <= 1'b0;
      sel_hi_q <= 1'b0;
      neg_q    <= 1'b0;
    end else if (flush) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
    end else if (start) begin
      prod_q   <= {{XLEN{1'b0}}, a_mag};
      opb_q    <= b_mag;
      cnt_q    <= CW'(XLEN);
      active_q <= 1'b1;
      is_div_q <= is_div;
      sel_hi_q <= sel_hi;
      // remainder follows the dividend sign, quotient the sign difference
      neg_q    <= is_div && sgn && (sel_hi ? a[XLEN-1] : (a[XLEN-1] ^ b[XLEN-1]));
    end else if (active_q) begin
      prod_q <= prod_step;
      cnt_q  <= cnt_q - CW'(1);
      if (done) active_q <= 1'b0;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Handshaked execute-stage ALU: single-cycle integer ops plus iterative RV-M ops.
module seq_alu
  import alu_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            cmp
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

  state_e          state_q, state_d;
  logic [XLEN-1:0] result_q, result_d, sc_res, md_res;
  logic            cmp_q, cmp_d, sc_cmp;
  logic            accept, md_start, md_busy, md_done;
  logic            b_zero, div_ovf, div_op, md_is_div, md_sgn, md_sel_hi;

  assign in_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
  assign accept    = in_valid && in_ready && !flush;
  assign out_valid = (state_q == S_DONE);
  assign result    = result_q;
  assign cmp       = cmp_q;

  assign b_zero    = (b == '0);
  assign div_ovf   = ((op == OP_DIV) || (op == OP_REM)) && (a == SMIN) && (b == '1);
  assign div_op    = (op >= OP_DIVU) && (op <= OP_REM);
  // Divide-by-zero and signed overflow finish in one cycle without iterating.
  assign md_start  = accept && is_muldiv(op) && !(div_op && (b_zero || div_ovf));
  assign md_is_div = div_op;
  assign md_sgn    = (op == OP_DIV) || (op == OP_REM);
  assign md_sel_hi = (op == OP_MULHU) || (op == OP_REMU) || (op == OP_REM);

  always_comb begin
    sc_res = '0;
    sc_cmp = 1'b0;
    case (op)
      OP_XOR:           sc_res = a ^ b;
      OP_ADD:           sc_res = a + b;
      OP_SUB:           sc_res = a - b;
      OP_AND:           sc_res = a & b;
      OP_OR:            sc_res = a | b;
      OP_SLL:           sc_res = a << b[SHW-1:0];
      OP_SRL:           sc_res = a >> b[SHW-1:0];
      OP_SRA:           sc_res = XLEN'($signed(a) >>> b[SHW-1:0]);
      OP_EQ:            sc_cmp = (a == b);
      OP_NE:            sc_cmp = (a != b);
      OP_LT:            sc_cmp = ($signed(a) < $signed(b));
      OP_LTU:           sc_cmp = (a < b);
      OP_DIVU, OP_DIV:  sc_res = b_zero ? '1 : a;
      OP_REMU, OP_REM:  sc_res = b_zero ? a : '0;
      default:          sc_res = '0;
    endcase
    if (sc_cmp) sc_res = XLEN'(1);
  end

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    cmp_d    = cmp_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if ((state_q == S_DONE) && out_ready) state_d = S_IDLE;
          if (accept) begin
            if (md_start) begin
              state_d = md_is_div ? S_DIV : S_MUL;
            end else begin
              state_d  = S_DONE;
              result_d = sc_res;
              cmp_d    = sc_cmp;
            end
          end
        end
        S_MUL, S_DIV: begin
          if (md_done) begin
            state_d  = S_DONE;
            result_d = md_res;
            cmp_d    = 1'b0;
          end else if (!md_busy) begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      cmp_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      cmp_q    <= cmp_d;
    end
  end

  muldiv_iter #(.XLEN(XLEN)) u_muldiv (
    .clk    (clk),
    .rst_n  (rst_n),
    .flush  (flush),
    .start  (md_start),
    .is_div (md_is_div),
    .sgn    (md_sgn),
    .sel_hi (md_sel_hi),
    .a      (a),
    .b      (b),
    .busy   (md_busy),
    .done   (md_done),
    .res    (md_res)
  );

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: directed corner cases plus randomized ops vs. a plain-arithmetic model.
module tb_seq_alu;
  import alu_pkg::*;

  localparam int XLEN = 64;
  localparam logic [63:0] SMIN = 64'h8000_0000_0000_0000;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            flush = 1'b0;
  logic            in_valid = 1'b0;
  logic            out_ready = 1'b1;
  logic            in_ready, out_valid, cmp;
  logic [4:0]      op = 5'd0;
  logic [XLEN-1:0] a = '0, b = '0, result;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct {
    logic [63:0] r;
    logic        c;
    int          lat;
    int          acc;
  } exp_t;

  exp_t q[$];
  bit   seen = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seq_alu #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .cmp       (cmp)
  );

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, expv);
    end
  endtask

  // Reference behaviour straight from the ISA rules.
  function automatic void model(input logic [4:0] o, input logic [63:0] x, input logic [63:0] y,
                                output logic [63:0] r, output logic c, output int lat);
    logic [127:0]       p;
    logic signed [63:0] sx, sy;
    logic               ovf;
    sx  = x;
    sy  = y;
    p   = {64'd0, x} * {64'd0, y};
    ovf = (x == SMIN) && (y == 64'hFFFF_FFFF_FFFF_FFFF);
    r   = 64'd0;
    c   = 1'b0;
    lat = 1;
    case (o)
      5'd0:  r = x ^ y;
      5'd1:  r = x + y;
      5'd2:  r = x - y;
      5'd3:  r = x & y;
      5'd4:  r = x | y;
      5'd5:  r = x << y[5:0];
      5'd6:  r = x >> y[5:0];
      5'd7:  r = sx >>> y[5:0];
      5'd8:  c = (x == y);
      5'd9:  c = (x != y);
      5'd10: c = (sx < sy);
      5'd11: c = (x < y);
      5'd12: begin r = p[63:0];   lat = 65; end
      5'd13: begin r = p[127:64]; lat = 65; end
      5'd14: if (y == 64'd0) r = 64'hFFFF_FFFF_FFFF_FFFF; else begin r = x / y; lat = 65; end
      5'd15: if (y == 64'd0) r = x; else begin r = x % y; lat = 65; end
      5'd16: if (y == 64'd0) r = 64'hFFFF_FFFF_FFFF_FFFF;
             else if (ovf) r = x;
             else begin r = sx / sy; lat = 65; end
      5'd17: if (y == 64'd0) r = x;
             else if (ovf) r = 64'd0;
             else begin r = sx % sy; lat = 65; end
      default: r = 64'd0;
    endcase
    if (c) r = 64'd1;
  endfunction

  // Called at posedge+1; returns at posedge+1 after the accept edge with in_valid still high.
  task automatic issue(input logic [4:0] o, input logic [63:0] x, input logic [63:0] y, input bit push);
    exp_t e;
    int   n;
    n = 0;
    in_valid = 1'b1;
    op = o;
    a = x;
    b = y;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 300) begin
        errors++;
        checks++;
        $display("FAIL accept_timeout: op %0d not accepted, in_ready %b", o, in_ready);
        break;
      end
      @(posedge clk);
      #1 out_ready = 1'b1;
    end
    if (push) begin
      model(o, x, y, e.r, e.c, e.lat);
      e.acc = cyc;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  // Drop in_valid and scramble the operand bus to show operands were captured.
  task automatic idle();
    in_valid = 1'b0;
    op = 5'($urandom);
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
  endtask

  task automatic drain();
    int n;
    n = 0;
    idle();
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() == 0 && !out_valid) break;
      n++;
      if (n > 500) begin
        errors++;
        checks++;
        $display("FAIL drain_timeout: %0d results outstanding, out_valid %b", q.size(), out_valid);
        q.delete();
        break;
      end
    end
  endtask

  function automatic logic [63:0] pick();
    case ($urandom_range(0, 6))
      0:       return 64'd0;
      1:       return 64'hFFFF_FFFF_FFFF_FFFF;
      2:       return SMIN;
      3:       return 64'($urandom_range(0, 20));
      4:       return -64'($urandom_range(1, 20));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // Monitor: pops the scoreboard whenever the DUT hands over a result.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && out_valid) begin
        if (q.size() == 0) begin
          errors++;
          checks++;
          $display("FAIL unexpected_out_valid: result %h cmp %b with nothing pending", result, cmp);
        end else begin
          if (!seen) begin
            chk("latency", 64'(cyc - q[0].acc), 64'(q[0].lat));
            seen = 1'b1;
          end
          if (out_ready) begin
            chk("result", result, q[0].r);
            chk("cmp", 64'(cmp), 64'(q[0].c));
            void'(q.pop_front());
            seen = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    logic [4:0] ro;

    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_result", result, 64'd0);
    chk("rst_cmp", 64'(cmp), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    issue(OP_ADD,   64'd5, 64'd7, 1'b1);
    issue(OP_SRA,   SMIN, 64'h44, 1'b1);
    issue(OP_MUL,   64'd3, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    issue(OP_MULHU, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    issue(OP_DIV,   64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1);
    issue(OP_REM,   64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1);
    issue(OP_DIVU,  64'd9, 64'd0, 1'b1);
    issue(OP_REM,   SMIN, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    issue(OP_EQ,    64'h1234, 64'h1234, 1'b1);
    issue(OP_LT,    64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1);
    issue(OP_LTU,   64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1);
    issue(5'd31,    64'd5, 64'd6, 1'b1);
    drain();

    // Held result with out_ready low, then a same-cycle release and new accept.
    out_ready = 1'b0;
    issue(OP_ADD, 64'd100, 64'd23, 1'b1);
    idle();
    repeat (10) begin
      @(negedge clk);
      chk("hold_result", result, 64'd123);
      chk("hold_in_ready", 64'(in_ready), 64'd0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    issue(OP_XOR, 64'hF0, 64'h3C, 1'b1);
    drain();

    // Back-to-back single-cycle ops accept every cycle.
    t0 = cyc;
    for (int i = 0; i < 8; i++) issue(5'(i), {$urandom, $urandom}, {$urandom, $urandom}, 1'b1);
    chk("throughput", 64'(cyc - t0), 64'd8);
    drain();

    // Flush wins over an offered op.
    flush = 1'b1;
    in_valid = 1'b1;
    op = OP_ADD;
    a = 64'd1;
    b = 64'd1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    idle();
    @(negedge clk);
    chk("flush_ignores_in", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;

    // Flush in the middle of a divide.
    issue(OP_DIV, -64'd100, 64'd7, 1'b0);
    idle();
    repeat (18) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    issue(OP_ADD, 64'd40, 64'd2, 1'b1);
    idle();
    repeat (80) @(posedge clk);
    #1;
    drain();

    // Asynchronous reset in the middle of a multiply.
    issue(OP_MUL, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0);
    idle();
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_result", result, 64'd0);
    chk("mid_rst_cmp", 64'(cmp), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    issue(OP_ADD, 64'd1000, 64'd24, 1'b1);
    idle();
    repeat (80) @(posedge clk);
    #1;
    drain();

    // Randomized mix with random consumer stalls.
    for (int i = 0; i < 80; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      ro = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(18, 31)) : 5'($urandom_range(0, 17));
      issue(ro, pick(), pick(), 1'b1);
      if ($urandom_range(0, 3) == 0) idle();
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
